// File: rtl/crc_pkg.sv
// Shared definitions for the streaming CRC encoder: FSM state encoding and CRC width helper.
package crc_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

  // CRC length for a generator of r bits.
  function automatic int crc_w(input int r);
    return r - 1;
  endfunction

endpackage

// File: rtl/crc_step.sv
// One serial LFSR step of the CRC remainder: feeds a single message bit, MSB-first.
module crc_step
  import crc_pkg::*;
#(
  parameter int           R   = 7,
  parameter logic [R-1:0] DIV = 7'b1111011
) (
  input  logic [R-2:0] rem_in,
  input  logic         bit_in,
  output logic [R-2:0] rem_out
);

  localparam int CRC_W = crc_w(R);

  logic fb;

  assign fb      = rem_in[CRC_W-1] ^ bit_in;
  assign rem_out = (rem_in << 1) ^ (fb ? DIV[CRC_W-1:0] : '0);

endmodule

// File: rtl/crc_stream_encoder.sv
// Streaming CRC encoder: collects an N-bit message W bits per beat, then presents {message, crc}
// until the consumer takes it.
module crc_stream_encoder
  import crc_pkg::*;
#(
  parameter int           N    = 16,
  parameter int           R    = 7,
  parameter logic [R-1:0] DIV  = 7'b1111011,
  parameter int           W    = 4,
  parameter logic [R-2:0] INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+R-2:0]   out_codeword,
  output logic [R-2:0]     out_crc
);

  localparam int CRC_W = crc_w(R);
  localparam int BEATS = N / W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t           state;
  logic [N-1:0]     msg;
  logic [CRC_W-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [CRC_W-1:0] chain [0:W];
  logic             last_beat;

  // Remainder advances through all W bits of a beat in one cycle; bit W-1 goes first.
  assign chain[0] = rem;
  for (genvar i = 0; i < W; i++) begin : g_step
    crc_step #(.R(R), .DIV(DIV)) u_step (
      .rem_in  (chain[i]),
      .bit_in  (in_data[W-1-i]),
      .rem_out (chain[i+1])
    );
  end

  assign last_beat = (cnt == CNT_W'(BEATS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
      cnt   <= '0;
      msg   <= '0;
      rem   <= INIT;
    end else if (state == ACCEPT) begin
      if (in_valid) begin
        msg <= (msg << W) | N'(in_data);
        rem <= chain[W];
        if (last_beat) begin
          cnt   <= '0;
          state <= EMIT;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end else begin
      // Beats offered while a codeword is pending are ignored.
      if (out_ready) begin
        state <= ACCEPT;
        rem   <= INIT;
      end
    end
  end

  assign in_ready     = (state == ACCEPT);
  assign out_valid    = (state == EMIT);
  assign out_codeword = {msg, rem};
  assign out_crc      = rem;

endmodule

// File: tb/tb_crc_stream_encoder.sv
// Self-checking bench for crc_stream_encoder in W=4, W=1 and W=16 configurations.
module tb_crc_stream_encoder;

  logic clk;
  logic rst;

  logic        iv4, ir4, ov4, or4;
  logic [3:0]  id4;
  logic [21:0] cw4;
  logic [5:0]  crc4;

  logic        iv1, ir1, ov1, or1;
  logic [0:0]  id1;
  logic [21:0] cw1;
  logic [5:0]  crc1;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] id16;
  logic [21:0] cw16;
  logic [5:0]  crc16;

  int n_checks;
  int n_fail;

  crc_stream_encoder #(.N(16), .R(7), .DIV(7'b1111011), .W(4), .INIT(6'd0)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_codeword(cw4), .out_crc(crc4));

  crc_stream_encoder #(.N(16), .R(7), .DIV(7'b1111011), .W(1), .INIT(6'd0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_codeword(cw1), .out_crc(crc1));

  crc_stream_encoder #(.N(16), .R(7), .DIV(7'b1111011), .W(16), .INIT(6'd0)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(id16),
    .out_valid(ov16), .out_ready(or16), .out_codeword(cw16), .out_crc(crc16));

  always #5 clk = ~clk;

  // Reference: mod-2 long division of message*x^6 by the generator.
  function automatic logic [5:0] ref_crc(input logic [15:0] m);
    logic [21:0] d;
    logic [21:0] g;
    d = {m, 6'b0};
    g = 22'(7'b1111011);
    for (int i = 21; i >= 6; i--)
      if (d[i]) d = d ^ (g << (i - 6));
    return d[5:0];
  endfunction

  function automatic logic [21:0] ref_cw(input logic [15:0] m);
    return {m, ref_crc(m)};
  endfunction

  // Sends one W=4 message; gap_mode inserts idle cycles before beats. Ends on the negedge after the last transfer.
  task automatic send4(input logic [15:0] m, input int gap_mode);
    for (int b = 0; b < 4; b++) begin
      if (gap_mode == 1 && b > 0) begin
        iv4 = 1'b0;
        repeat (2) @(negedge clk);
      end else if (gap_mode == 2) begin
        iv4 = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      iv4 = 1'b1;
      id4 = m[15-4*b -: 4];
      @(negedge clk);
    end
    iv4 = 1'b0;
  endtask

  task automatic take4();
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs got ir=%b ov=%b want ir=1 ov=0", ir4, ov4);
    end
    n_checks++;
    if (cw4 !== 22'h0 || crc4 !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_out got cw=%h crc=%h want 0/0", cw4, crc4);
    end
    n_checks++;
    if (ir1 !== 1'b1 || ov1 !== 1'b0 || ir16 !== 1'b1 || ov16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs_w1w16 got %b%b%b%b want 1010", ir1, ov1, ir16, ov16);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    or4 = 1'b1;
    send4(16'hE53D, 0);
    n_checks++;
    if (ov4 !== 1'b1 || ir4 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency got ov=%b ir=%b want ov=1 ir=0", ov4, ir4);
    end
    n_checks++;
    if (crc4 !== 6'b111100) begin
      n_fail++;
      $display("FAIL basic_crc got %b want 111100", crc4);
    end
    n_checks++;
    if (cw4 !== 22'h394F7C) begin
      n_fail++;
      $display("FAIL basic_cw got %h want 394f7c", cw4);
    end
    @(negedge clk);
    or4 = 1'b0;
    n_checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || crc4 !== 6'h0) begin
      n_fail++;
      $display("FAIL basic_return got ir=%b ov=%b crc=%h want 1/0/00", ir4, ov4, crc4);
    end
  endtask

  task automatic test_backpressure();
    or4 = 1'b0;
    send4(16'hE53D, 0);
    for (int c = 0; c < 5; c++) begin
      iv4 = 1'b1;
      id4 = 4'($urandom);
      n_checks++;
      if (ov4 !== 1'b1 || ir4 !== 1'b0 || cw4 !== 22'h394F7C) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got ov=%b ir=%b cw=%h want 1/0/394f7c", c, ov4, ir4, cw4);
      end
      @(negedge clk);
    end
    iv4 = 1'b0;
    n_checks++;
    if (cw4 !== 22'h394F7C) begin
      n_fail++;
      $display("FAIL bp_ignore_in got %h want 394f7c", cw4);
    end
    take4();
    n_checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got ir=%b ov=%b want 1/0", ir4, ov4);
    end
  endtask

  task automatic test_gaps();
    send4(16'hE53D, 1);
    n_checks++;
    if (ov4 !== 1'b1 || cw4 !== 22'h394F7C) begin
      n_fail++;
      $display("FAIL gaps_cw got ov=%b cw=%h want 1/394f7c", ov4, cw4);
    end
    take4();
  endtask

  task automatic test_midreset();
    iv4 = 1'b1;
    id4 = 4'h9;
    @(negedge clk);
    id4 = 4'h6;
    @(negedge clk);
    iv4 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ir4 !== 1'b1 || cw4 !== 22'h0) begin
      n_fail++;
      $display("FAIL midreset_clear got ir=%b cw=%h want 1/0", ir4, cw4);
    end
    send4(16'hE53D, 0);
    n_checks++;
    if (ov4 !== 1'b1 || cw4 !== 22'h394F7C) begin
      n_fail++;
      $display("FAIL midreset_cw got ov=%b cw=%h want 1/394f7c", ov4, cw4);
    end
    // Reset while a codeword is pending, even with out_ready high.
    or4 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    or4 = 1'b0;
    n_checks++;
    if (ov4 !== 1'b0 || ir4 !== 1'b1 || cw4 !== 22'h0) begin
      n_fail++;
      $display("FAIL emitreset got ov=%b ir=%b cw=%h want 0/1/0", ov4, ir4, cw4);
    end
  endtask

  task automatic test_zero_and_back_to_back();
    logic [15:0] mb;
    send4(16'h0000, 0);
    n_checks++;
    if (crc4 !== 6'h0 || cw4 !== 22'h0 || ov4 !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_msg got ov=%b cw=%h crc=%h want 1/0/0", ov4, cw4, crc4);
    end
    take4();
    send4(16'hE53D, 0);
    // Offer the next message's first beat during the handshake cycle; it must not be taken there.
    mb = 16'($urandom);
    or4 = 1'b1;
    iv4 = 1'b1;
    id4 = mb[15:12];
    @(negedge clk);
    or4 = 1'b0;
    n_checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_release got ir=%b ov=%b want 1/0", ir4, ov4);
    end
    send4(mb, 0);
    n_checks++;
    if (ov4 !== 1'b1 || cw4 !== ref_cw(mb)) begin
      n_fail++;
      $display("FAIL b2b_cw got ov=%b cw=%h want 1/%h", ov4, cw4, ref_cw(mb));
    end
    take4();
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int k = 0; k < 20; k++) begin
      m = 16'($urandom);
      send4(m, 2);
      n_checks++;
      if (ov4 !== 1'b1 || cw4 !== ref_cw(m) || crc4 !== ref_crc(m)) begin
        n_fail++;
        $display("FAIL rand_cw msg %h got ov=%b cw=%h want 1/%h", m, ov4, cw4, ref_cw(m));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_checks++;
      if (cw4 !== ref_cw(m)) begin
        n_fail++;
        $display("FAIL rand_hold msg %h got %h want %h", m, cw4, ref_cw(m));
      end
      take4();
    end
  endtask

  task automatic test_w1();
    logic [15:0] m;
    for (int k = 0; k < 4; k++) begin
      m = (k == 0) ? 16'hE53D : 16'($urandom);
      for (int b = 0; b < 16; b++) begin
        iv1 = 1'b1;
        id1 = m[15-b];
        @(negedge clk);
        if (b < 15) begin
          n_checks++;
          if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_early beat %0d got ov=%b ir=%b want 0/1", b, ov1, ir1);
          end
        end
      end
      iv1 = 1'b0;
      n_checks++;
      if (ov1 !== 1'b1 || cw1 !== ref_cw(m)) begin
        n_fail++;
        $display("FAIL w1_cw msg %h got ov=%b cw=%h want 1/%h", m, ov1, cw1, ref_cw(m));
      end
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
    end
  endtask

  task automatic test_w16();
    logic [15:0] m;
    for (int k = 0; k < 4; k++) begin
      m = (k == 0) ? 16'hE53D : 16'($urandom);
      iv16 = 1'b1;
      id16 = m;
      @(negedge clk);
      iv16 = 1'b0;
      n_checks++;
      if (ov16 !== 1'b1 || cw16 !== ref_cw(m) || crc16 !== ref_crc(m)) begin
        n_fail++;
        $display("FAIL w16_cw msg %h got ov=%b cw=%h want 1/%h", m, ov16, cw16, ref_cw(m));
      end
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
      n_checks++;
      if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
        n_fail++;
        $display("FAIL w16_release got ir=%b ov=%b want 1/0", ir16, ov16);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk = 1'b0;
    rst = 1'b1;
    iv4 = 1'b0;  id4 = '0;  or4 = 1'b0;
    iv1 = 1'b0;  id1 = '0;  or1 = 1'b0;
    iv16 = 1'b0; id16 = '0; or16 = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_zero_and_back_to_back();
    test_random();
    test_w1();
    test_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream_encoder.md
CRC_STREAM_ENCODER -- requirements
Module: crc_stream_encoder

Interface
REQ-001 Parameter N, default 16: message length in bits.
REQ-002 Parameter R, default 7: generator width in bits; CRC length is R-1.
REQ-003 Parameter DIV, default 7'b1111011: generator polynomial, MSB-first; DIV[R-1] and DIV[0] shall be 1.
REQ-004 Parameter W, default 4: message bits accepted per beat; 1 <= W <= N and N mod W == 0.
REQ-005 Parameter INIT, default all-zero (R-1 bits): remainder seed loaded at reset and at the start of each message.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  in_data beat is valid.
REQ-009 in_ready  output  1  block can accept a beat.
REQ-010 in_data  input  W  message beat; MSB is the earliest bit on the wire.
REQ-011 out_valid  output  1  codeword available.
REQ-012 out_ready  input  1  consumer accepts the codeword.
REQ-013 out_codeword  output  N+R-1  {message, crc}; message in the upper N bits.
REQ-014 out_crc  output  R-1  remainder of message*x^(R-1) mod DIV, seeded with INIT.

Function
REQ-015 Two states: ACCEPT and EMIT; reset enters ACCEPT.
REQ-016 In ACCEPT, in_ready shall be 1 and out_valid 0; in EMIT, in_ready shall be 0 and out_valid 1.
REQ-017 A beat transfers when in_valid and in_ready are both 1; no other cycle changes the message register, remainder or beat counter.
REQ-018 Each transfer shifts W bits MSB-first into the message register and advances the remainder through W single-bit LFSR steps in that same cycle.
REQ-019 Feedback per bit: fb = rem[R-2] ^ bit; rem = (rem << 1) ^ (fb ? DIV[R-2:0] : 0).
REQ-020 Zero-appending is implicit; the remainder after N bits is the final CRC, and no flush cycles occur.
REQ-021 The beat counter counts 0 .. N/W-1 and wraps to 0 on the transfer of beat N/W-1; that transfer moves the FSM to EMIT.
REQ-022 Latency: out_valid rises on the cycle after the last beat transfers.
REQ-023 In EMIT, out_codeword and out_crc shall hold stable until out_valid and out_ready are both 1 in the same cycle.
REQ-024 On that handshake the FSM returns to ACCEPT and the remainder reloads INIT.
REQ-025 in_ready rises the cycle after the handshake; a beat cannot be accepted in the same cycle the codeword is taken.
REQ-026 Idle cycles (in_valid=0) between beats shall not alter the result.
REQ-027 in_valid during EMIT shall be ignored, with no state change.
REQ-028 With W=N the block accepts one beat per message; with W=1 it accepts N beats.

Reset
REQ-029 When rst=1 at a clock edge, the block shall enter ACCEPT, zero the beat counter and message register, and load the remainder with INIT; reset overrides any simultaneous handshake.
REQ-030 Output values during and after reset: in_ready=1, out_valid=0, out_codeword=0 in its message field, and out_crc=INIT.
REQ-031 Reset mid-message or during EMIT discards the partial message or undelivered codeword; the next beat is treated as beat 0.

Structure
REQ-032 Shared package crc_pkg shall hold the state encoding (ACCEPT=0, EMIT=1) and the width constant CRC_W = R-1, expressed as a helper.
REQ-033 One combinational sub-module, crc_step, shall perform one bit of REQ-019.
REQ-034 crc_stream_encoder shall chain W instances of crc_step with a generate loop.

Verification (N=16, R=7, DIV=1111011, INIT=0 unless noted)
REQ-035 Basic case, W=4: beats 0xE, 0x5, 0x3, 0xD on consecutive cycles with out_ready=1 -> out_valid=1 one cycle after the 4th beat; out_crc=6'b111100; out_codeword=22'h394F7C.
REQ-036 Backpressure: same message with out_ready=0 for 5 cycles -> out_valid and out_codeword=22'h394F7C stable throughout; in_ready=0 throughout; in_ready=1 the cycle after out_ready rises.
REQ-037 Gaps and reset: in_valid toggled 1,0,0,1,... -> same codeword. Separately, 2 beats, then rst for 1 cycle, then the full message -> same codeword.
REQ-038 Width configurations: W=1 with 16 beats, and W=16 with the single beat 16'hE53D -> out_codeword=22'h394F7C in each; out_valid occurs 1 cycle after the final beat.
REQ-039 All-zero message -> out_crc=0 and out_codeword=0. Back-to-back: the second message is accepted starting the cycle after the first handshake, and its result is independent of the first message.
